// File: rtl/procyon_lsu_lq_replay_sel_pkg.sv
// Shared constants for the load-queue replay selector.
// Provides the op width and load op encodings used on the replay port.
package procyon_lsu_lq_replay_sel_pkg;

    localparam int PCYN_OP_WIDTH = 5;

    typedef enum logic [PCYN_OP_WIDTH-1:0] {
        PCYN_OP_LB  = 5'd0,
        PCYN_OP_LH  = 5'd1,
        PCYN_OP_LW  = 5'd2,
        PCYN_OP_LBU = 5'd3,
        PCYN_OP_LHU = 5'd4
    } pcyn_op_t;

endpackage

// File: rtl/procyon_lsu_lq_replay_sel_picker.sv
// Round-robin picker: lowest set request at or above i_ptr, else lowest overall.
// Ports: i_req, i_ptr in; o_grant (one-hot), o_grant_idx, o_valid out.
module procyon_rr_picker #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         i_req,
    input  logic [$clog2(WIDTH)-1:0] i_ptr,
    output logic [WIDTH-1:0]         o_grant,
    output logic [$clog2(WIDTH)-1:0] o_grant_idx,
    output logic                     o_valid
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   mask;
    logic [2*WIDTH-1:0] dbl_req;
    logic [IDX_W:0]     pos;
    logic               found;

    // Lower half holds requests at/after the pointer, upper half all requests,
    // so one priority scan from bit 0 implements the wrap-around search.
    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= int'(i_ptr)) mask[i] = 1'b1;
        end
        dbl_req = {i_req, i_req & mask};
        pos     = '0;
        found   = 1'b0;
        for (int i = 0; i < 2*WIDTH; i++) begin
            if (!found && dbl_req[i]) begin
                found = 1'b1;
                pos   = (IDX_W+1)'(i);
            end
        end
    end

    assign o_valid     = |i_req;
    assign o_grant_idx = pos[IDX_W-1:0];
    assign o_grant     = o_valid ? (WIDTH'(1) << o_grant_idx) : '0;

endmodule

// File: rtl/procyon_lsu_lq_replay_sel.sv
// Load-queue replay scheduler: round-robin pick of a replayable entry,
// one-hot replay enable back to the LQ, and a single-slot output buffer.
// Ports: clk, n_rst, i_flush, i_stall, per-entry replayable/op/tag/addr in;
// o_replay_en (combinational grant), buffered o_replay_* and o_replay_select out.
module procyon_lsu_lq_replay_sel
    import procyon_lsu_lq_replay_sel_pkg::*;
#(
    parameter int OPTN_LQ_DEPTH      = 8,
    parameter int OPTN_ADDR_WIDTH    = 32,
    parameter int OPTN_ROB_IDX_WIDTH = 5
) (
    input  logic                                               clk,
    input  logic                                               n_rst,
    input  logic                                               i_flush,
    input  logic [OPTN_LQ_DEPTH-1:0]                           i_replayable,
    input  logic [OPTN_LQ_DEPTH-1:0][PCYN_OP_WIDTH-1:0]        i_replay_op,
    input  logic [OPTN_LQ_DEPTH-1:0][OPTN_ROB_IDX_WIDTH-1:0]   i_replay_tag,
    input  logic [OPTN_LQ_DEPTH-1:0][OPTN_ADDR_WIDTH-1:0]      i_replay_addr,
    output logic [OPTN_LQ_DEPTH-1:0]                           o_replay_en,
    input  logic                                               i_stall,
    output logic                                               o_replay_valid,
    output logic [PCYN_OP_WIDTH-1:0]                           o_replay_op,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]                      o_replay_tag,
    output logic [OPTN_ADDR_WIDTH-1:0]                         o_replay_addr,
    output logic [OPTN_LQ_DEPTH-1:0]                           o_replay_select
);

    localparam int IDX_W = $clog2(OPTN_LQ_DEPTH);

    logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic                          valid_q, valid_d;
    logic [OPTN_LQ_DEPTH-1:0]      select_q, select_d;
    logic [PCYN_OP_WIDTH-1:0]      op_q;
    logic [OPTN_ROB_IDX_WIDTH-1:0] tag_q;
    logic [OPTN_ADDR_WIDTH-1:0]    addr_q;

    logic [OPTN_LQ_DEPTH-1:0] pick_grant;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_valid;
    logic                     can_grant;
    logic                     grant_en;
    logic                     consumed;

    procyon_rr_picker #(
        .WIDTH(OPTN_LQ_DEPTH)
    ) u_picker (
        .i_req      (i_replayable),
        .i_ptr      (rr_ptr_q),
        .o_grant    (pick_grant),
        .o_grant_idx(pick_idx),
        .o_valid    (pick_valid)
    );

    // Gating with n_rst keeps the enable quiet while reset is held.
    assign can_grant   = ~i_flush & (~valid_q | ~i_stall);
    assign grant_en    = n_rst & can_grant & pick_valid;
    assign consumed    = valid_q & ~i_stall;
    assign o_replay_en = grant_en ? pick_grant : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        valid_d  = valid_q;
        select_d = select_q;
        if (i_flush) begin
            valid_d  = 1'b0;
            select_d = '0;
        end else if (grant_en) begin
            valid_d  = 1'b1;
            select_d = pick_grant;
            rr_ptr_d = pick_idx + 1'b1;
        end else if (consumed) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            select_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            select_q <= select_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (grant_en) begin
            op_q   <= i_replay_op[pick_idx];
            tag_q  <= i_replay_tag[pick_idx];
            addr_q <= i_replay_addr[pick_idx];
        end
    end

    assign o_replay_valid  = valid_q;
    assign o_replay_op     = op_q;
    assign o_replay_tag    = tag_q;
    assign o_replay_addr   = addr_q;
    assign o_replay_select = select_q;

endmodule

// File: tb/tb_procyon_lsu_lq_replay_sel.sv
// Randomized scoreboard bench for the LQ replay selector (depth 4).
// A reference model predicts grants; a monitor checks the output buffer.
module tb_procyon_lsu_lq_replay_sel;
    import procyon_lsu_lq_replay_sel_pkg::*;

    localparam int D  = 4;
    localparam int AW = 32;
    localparam int TW = 5;

    logic                          clk = 1'b0;
    logic                          n_rst;
    logic                          i_flush;
    logic [D-1:0]                  i_replayable;
    logic [D-1:0][PCYN_OP_WIDTH-1:0] i_replay_op;
    logic [D-1:0][TW-1:0]          i_replay_tag;
    logic [D-1:0][AW-1:0]          i_replay_addr;
    logic [D-1:0]                  o_replay_en;
    logic                          i_stall;
    logic                          o_replay_valid;
    logic [PCYN_OP_WIDTH-1:0]      o_replay_op;
    logic [TW-1:0]                 o_replay_tag;
    logic [AW-1:0]                 o_replay_addr;
    logic [D-1:0]                  o_replay_select;

    procyon_lsu_lq_replay_sel #(
        .OPTN_LQ_DEPTH     (D),
        .OPTN_ADDR_WIDTH   (AW),
        .OPTN_ROB_IDX_WIDTH(TW)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_flush        (i_flush),
        .i_replayable   (i_replayable),
        .i_replay_op    (i_replay_op),
        .i_replay_tag   (i_replay_tag),
        .i_replay_addr  (i_replay_addr),
        .o_replay_en    (o_replay_en),
        .i_stall        (i_stall),
        .o_replay_valid (o_replay_valid),
        .o_replay_op    (o_replay_op),
        .o_replay_tag   (o_replay_tag),
        .o_replay_addr  (o_replay_addr),
        .o_replay_select(o_replay_select)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PCYN_OP_WIDTH-1:0] op;
        logic [TW-1:0]            tag;
        logic [AW-1:0]            addr;
        logic [D-1:0]             sel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   run = 1'b0;
    bit   done = 1'b0;
    int   m_ptr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < D; i++) begin
            i_replay_op[i]   = PCYN_OP_WIDTH'($urandom_range(0, 4));
            i_replay_tag[i]  = TW'($urandom);
            i_replay_addr[i] = $urandom;
        end
    endtask

    // Monitor: compares the buffered replay against the scoreboard head
    // and retires it once the LSU takes it or a flush drops it.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (run && !done) begin
                chk("valid", 64'(o_replay_valid), 64'(exp_q.size() != 0));
                if (o_replay_valid && exp_q.size() != 0) begin
                    chk("op",     64'(o_replay_op),     64'(exp_q[0].op));
                    chk("tag",    64'(o_replay_tag),    64'(exp_q[0].tag));
                    chk("addr",   64'(o_replay_addr),   64'(exp_q[0].addr));
                    chk("select", 64'(o_replay_select), 64'(exp_q[0].sel));
                end
                if (exp_q.size() != 0 && (!i_stall || i_flush))
                    void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int   sel;
        bit   full;
        bit   grant;
        logic [D-1:0] exp_en;
        exp_t e;

        n_rst = 1'b0;
        i_flush = 1'b0;
        i_stall = 1'b0;
        i_replayable = 4'b1111;
        rand_payload();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_en",     64'(o_replay_en),     64'h0);
        chk("rst_valid",  64'(o_replay_valid),  64'h0);
        chk("rst_select", 64'(o_replay_select), 64'h0);
        @(negedge clk);
        n_rst = 1'b1;
        run = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            rand_payload();
            if (c < 12) begin
                i_replayable = 4'b1111;
                i_stall = 1'b0;
                i_flush = 1'b0;
            end else begin
                i_replayable = D'($urandom);
                i_stall = ($urandom_range(0, 3) == 0);
                i_flush = ($urandom_range(0, 15) == 0);
            end
            #1;
            // Model: search entries in order ptr, ptr+1, ... modulo depth.
            full  = (exp_q.size() != 0);
            grant = 1'b0;
            sel   = 0;
            if (!i_flush && (!full || !i_stall)) begin
                for (int k = 0; k < D; k++) begin
                    if (!grant && i_replayable[(m_ptr + k) % D]) begin
                        grant = 1'b1;
                        sel   = (m_ptr + k) % D;
                    end
                end
            end
            exp_en = '0;
            if (grant) exp_en[sel] = 1'b1;
            chk("replay_en", 64'(o_replay_en), 64'(exp_en));
            #2;
            if (grant) begin
                e.op   = i_replay_op[sel];
                e.tag  = i_replay_tag[sel];
                e.addr = i_replay_addr[sel];
                e.sel  = exp_en;
                exp_q.push_back(e);
                m_ptr = (sel + 1) % D;
            end
            @(negedge clk);
        end

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
